ce_gen: RTL and testbench
=========================

CE_GEN -- requirements
Module: ce_gen

Interface
REQ-001 SHALL have port: clock  input  1  28.333 MHz master clock from the DCM-based clock stage; only clock in block.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: contend  input  1  memory/IO contention request from video side; 1 = stretch CPU clock.
REQ-004 SHALL have port: turbo  input  1  1 = CPU enables at 7 MHz; present only when TURBO_EN defined.
REQ-005 SHALL have port: ce7p  output  1  pixel-clock rising-phase enable, 1 clock wide.
REQ-006 SHALL have port: ce7n  output  1  pixel-clock falling-phase enable, 1 clock wide.
REQ-007 SHALL have port: ce35p  output  1  CPU clock rising-phase enable, 1 clock wide.
REQ-008 SHALL have port: ce35n  output  1  CPU clock falling-phase enable, 1 clock wide.
REQ-009 SHALL have port: ce175  output  1  PSG enable (1.77 MHz), 1 clock wide.
REQ-010 SHALL have port: cpuclk  output  1  level image of emulated Z80 clock.

Function
REQ-011 SHALL hold a 4-bit free-running counter cnt, incremented every clock, wrapping 15->0.
REQ-012 All outputs SHALL be registers; each pulse SHALL be high exactly in the cycle where cnt holds its decode value.
REQ-013 ce7p SHALL be high when cnt[1:0]=01; ce7n when cnt[1:0]=11 (period 4 clocks).
REQ-014 ce175 SHALL be high when cnt=1111 (period 16 clocks), independent of contend/turbo.
REQ-015 Normal mode: ce35p SHALL be high when cnt[2:0]=011, ce35n when cnt[2:0]=111, unless stalled.
REQ-016 contend SHALL be sampled only in cycles where cnt[2:0]=010; if 1, the next ce35p and the ce35n following it SHALL both be suppressed (one full CPU period stretched).
REQ-017 contend SHALL be ignored while a stretch is in progress; back-to-back stretches SHALL occur only via a fresh sample at the next cnt[2:0]=010.
REQ-018 cpuclk SHALL go 1 in the cycle after ce35p and 0 in the cycle after ce35n; it SHALL remain 1 throughout a stretch.
REQ-019 ce35p and ce35n SHALL never be high in the same cycle; ce7p/ce7n likewise.

Reset
REQ-020 While reset=1: cnt=0, all pulse outputs 0, cpuclk=1, stall flag 0, effective turbo 0.
REQ-021 Reset assertion mid-stretch SHALL abort the stretch immediately; no pulse SHALL appear during reset.
REQ-022 After release, the first edge SHALL move cnt to 1; first ce7p in that cycle, first ce35p when cnt=3.

Configuration
REQ-023 Macro TURBO_EN SHALL compile in port turbo and 7 MHz CPU mode.
REQ-024 With TURBO_EN and effective turbo=1: ce35p at cnt[1:0]=01, ce35n at cnt[1:0]=11, contend sampled at cnt[1:0]=00 with same suppression rule.
REQ-025 turbo SHALL be registered into effective turbo only in cycles where cnt[2:0]=111 and no stretch is pending, so a mode change never produces a short or doubled CPU phase.
REQ-026 Without TURBO_EN: no turbo port, CPU enables fixed at 3.5 MHz, behaviour identical to TURBO_EN with turbo=0.

Structure
REQ-027 Shared package SHALL hold counter width (4) and decode constants for 7 MHz, 3.5 MHz and PSG phases.
REQ-028 Block SHALL be a single module; no sub-module.

Verification
REQ-029 Reset released, contend=0, 64 clocks -> 16 ce7p, 16 ce7n, 8 ce35p, 8 ce35n, 4 ce175; ce35p first at cycle 3.
REQ-030 contend=1 for one cycle at cnt=2 -> ce35p at cnt=3 and ce35n at cnt=7 absent, cpuclk 1 for 12 clocks, next ce35p at cnt=11.
REQ-031 contend held 1 continuously -> no ce35p/ce35n; ce7p/ce7n/ce175 unchanged; cpuclk constant 1.
REQ-032 reset pulsed while cnt=5 during stretch -> all pulses 0, cpuclk=1, restart matches REQ-022.
REQ-033 TURBO_EN, turbo 0->1 at cnt=4 -> 3.5 MHz spacing until cnt=7, then ce35p every 4 clocks from cnt=9; no two ce35p closer than 4 clocks.
REQ-034 Every scenario -> ce35p/ce35n strictly alternate, never coincide.

Source files
------------

// File: rtl/ce_gen_pkg.sv
// ce_gen_pkg -- shared constants and decode helper for the clock-enable
// generator.
//   CNT_W          : width of the free-running phase counter
//   CE7*_PH        : pixel-clock (7 MHz) phases on cnt[1:0]
//   PSG_PH         : PSG (1.77 MHz) phase on the full counter
//   CPU_*_PH       : CPU 3.5 MHz phases on cnt[2:0] (sample / rise / fall)
//   TRB_*_PH       : CPU 7 MHz (turbo) phases, compared against {0,cnt[1:0]}
//   MODE_SW_PH     : only phase where the effective turbo mode may change
package ce_gen_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0]       CE7P_PH = 2'b01;
  localparam logic [1:0]       CE7N_PH = 2'b11;
  localparam logic [CNT_W-1:0] PSG_PH  = 4'hF;

  localparam logic [2:0] CPU_SMP_PH = 3'b010;
  localparam logic [2:0] CPU_P_PH   = 3'b011;
  localparam logic [2:0] CPU_N_PH   = 3'b111;

  localparam logic [2:0] TRB_SMP_PH = 3'b000;
  localparam logic [2:0] TRB_P_PH   = 3'b001;
  localparam logic [2:0] TRB_N_PH   = 3'b011;

  localparam logic [2:0] MODE_SW_PH = 3'b111;

  // CPU phase decode for one counter value: contend-sample slot, rising
  // enable slot, falling enable slot.
  typedef struct packed {
    logic smp;
    logic p;
    logic n;
  } cpu_dec_t;

  function automatic cpu_dec_t cpu_decode(input logic [2:0] ph, input logic trb);
    cpu_dec_t d;
    logic [2:0] tph;
    tph = {1'b0, ph[1:0]};
    if (trb) begin
      d.smp = (tph == TRB_SMP_PH);
      d.p   = (tph == TRB_P_PH);
      d.n   = (tph == TRB_N_PH);
    end else begin
      d.smp = (ph == CPU_SMP_PH);
      d.p   = (ph == CPU_P_PH);
      d.n   = (ph == CPU_N_PH);
    end
    return d;
  endfunction

endpackage

// File: rtl/ce_gen.sv
// ce_gen -- clock-enable generator for a 28.333 MHz master clock.
// Produces 1-clock-wide enables for the 7 MHz pixel clock, the 3.5 MHz
// (or 7 MHz turbo) CPU clock with contention stretching, and the 1.77 MHz
// PSG, plus a level image of the emulated CPU clock.
// Build option: define TURBO_EN to add the turbo input and 7 MHz CPU mode.
// Ports:
//   clock   : master clock (only clock in the block)
//   reset   : asynchronous, active-high reset
//   contend : contention request; 1 = stretch the CPU clock by one period
//   turbo   : (TURBO_EN only) request 7 MHz CPU enables
//   ce7p/ce7n   : pixel-clock rising / falling phase enables
//   ce35p/ce35n : CPU clock rising / falling phase enables
//   ce175   : PSG enable
//   cpuclk  : level image of the CPU clock
module ce_gen
  import ce_gen_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic contend,
`ifdef TURBO_EN
  input  logic turbo,
`endif
  output logic ce7p,
  output logic ce7n,
  output logic ce35p,
  output logic ce35n,
  output logic ce175,
  output logic cpuclk
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ce7p_q, ce7p_d, ce7n_q, ce7n_d;
  logic ce35p_q, ce35p_d, ce35n_q, ce35n_d;
  logic ce175_q, ce175_d;
  logic cpuclk_q, cpuclk_d;
  logic stall_q, stall_d;
  logic turbo_q, turbo_d;
  cpu_dec_t dec_cur, dec_nxt;

`ifdef TURBO_EN
  // Mode only changes at the end of a full 3.5 MHz period with no stretch
  // in flight, so neither mode sees a truncated or doubled phase.
  always_comb begin
    turbo_d = turbo_q;
    if (cnt_q[2:0] == MODE_SW_PH && !stall_q) turbo_d = turbo;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) turbo_q <= 1'b0;
    else       turbo_q <= turbo_d;
  end
`else
  assign turbo_d = 1'b0;
  assign turbo_q = 1'b0;
`endif

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    dec_cur = cpu_decode(cnt_q[2:0], turbo_q);

    // Stretch: latched from contend at the sample slot, held through the
    // suppressed rise and fall, dropped in the slot of the suppressed fall.
    // contend is not looked at while a stretch is active.
    stall_d = stall_q;
    if (stall_q) begin
      if (dec_cur.n) stall_d = 1'b0;
    end else if (dec_cur.smp) begin
      stall_d = contend;
    end

    // Outputs are registered from the next counter value so each pulse is
    // high in exactly the cycle where cnt holds its decode value.
    dec_nxt = cpu_decode(cnt_d[2:0], turbo_d);
    ce7p_d  = (cnt_d[1:0] == CE7P_PH);
    ce7n_d  = (cnt_d[1:0] == CE7N_PH);
    ce175_d = (cnt_d == PSG_PH);
    ce35p_d = dec_nxt.p && !stall_d;
    ce35n_d = dec_nxt.n && !stall_d;

    // During a stretch cpuclk rises where the suppressed rise would have
    // taken it and then holds high until the next real falling enable.
    cpuclk_d = cpuclk_q;
    if (ce35p_q || stall_q) cpuclk_d = 1'b1;
    else if (ce35n_q)       cpuclk_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      ce7p_q   <= 1'b0;
      ce7n_q   <= 1'b0;
      ce35p_q  <= 1'b0;
      ce35n_q  <= 1'b0;
      ce175_q  <= 1'b0;
      cpuclk_q <= 1'b1;
      stall_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ce7p_q   <= ce7p_d;
      ce7n_q   <= ce7n_d;
      ce35p_q  <= ce35p_d;
      ce35n_q  <= ce35n_d;
      ce175_q  <= ce175_d;
      cpuclk_q <= cpuclk_d;
      stall_q  <= stall_d;
    end
  end

  assign ce7p   = ce7p_q;
  assign ce7n   = ce7n_q;
  assign ce35p  = ce35p_q;
  assign ce35n  = ce35n_q;
  assign ce175  = ce175_q;
  assign cpuclk = cpuclk_q;

endmodule

// File: tb/tb_ce_gen.sv
// tb_ce_gen -- directed bench for ce_gen. Output vector order is
// {ce7p, ce7n, ce35p, ce35n, ce175, cpuclk}; expected rows are hand-written
// per counter value. Define TURBO_EN to also exercise the turbo mode.
module tb_ce_gen;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic contend = 1'b0;
  logic turbo = 1'b0;
  logic ce7p, ce7n, ce35p, ce35n, ce175, cpuclk;

  ce_gen dut (
    .clock   (clock),
    .reset   (reset),
    .contend (contend),
`ifdef TURBO_EN
    .turbo   (turbo),
`endif
    .ce7p    (ce7p),
    .ce7n    (ce7n),
    .ce35p   (ce35p),
    .ce35n   (ce35n),
    .ce175   (ce175),
    .cpuclk  (cpuclk)
  );

  always #5 clock = ~clock;

  wire [5:0] outs = {ce7p, ce7n, ce35p, ce35n, ce175, cpuclk};

  // Steady-state 3.5 MHz rows, indexed by cnt.
  localparam logic [5:0] STEADY [16] = '{
    6'b000000, 6'b100000, 6'b000000, 6'b011000,
    6'b000001, 6'b100001, 6'b000001, 6'b010101,
    6'b000000, 6'b100000, 6'b000000, 6'b011000,
    6'b000001, 6'b100001, 6'b000001, 6'b010111};

  // Stretch sampled at cnt=2: rows for cnt 3..15 then 0.
  localparam logic [5:0] STR [14] = '{
    6'b010000, 6'b000001, 6'b100001, 6'b000001, 6'b010001,
    6'b000001, 6'b100001, 6'b000001, 6'b011001, 6'b000001,
    6'b100001, 6'b000001, 6'b010111, 6'b000000};

  // Turbo requested at cnt=4 from reset: rows for cnt 5..15 then 0..3.
  localparam logic [5:0] TRB [15] = '{
    6'b100001, 6'b000001, 6'b010101, 6'b000000, 6'b101000,
    6'b000001, 6'b010101, 6'b000000, 6'b101000, 6'b000001,
    6'b010111, 6'b000000, 6'b101000, 6'b000001, 6'b010101};

  // Turbo stretch sampled at cnt=4: rows for cnt 5..12.
  localparam logic [5:0] TRB2 [8] = '{
    6'b100000, 6'b000001, 6'b010001, 6'b000001,
    6'b101001, 6'b000001, 6'b010101, 6'b000000};

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Background monitor: coincidence, alternation and ce35p spacing.
  int coinc = 0, alt_err = 0, min_gap = 1000, gcyc = 0, last_p = -1;
  logic last_was_p = 1'b0;
  always @(negedge clock) begin
    gcyc++;
    if (reset) begin
      last_was_p = 1'b0;
      last_p = -1;
    end else begin
      if (ce35p && ce35n) coinc++;
      if (ce7p && ce7n) coinc++;
      if (ce35p) begin
        if (last_was_p) alt_err++;
        last_was_p = 1'b1;
        if (last_p >= 0 && gcyc - last_p < min_gap) min_gap = gcyc - last_p;
        last_p = gcyc;
      end
      if (ce35n) begin
        if (!last_was_p) alt_err++;
        last_was_p = 1'b0;
      end
    end
  end

  initial begin
    int c, n7p, n7n, n35p, n35n, n175, first_p, hi;
    logic [5:0] exp;

    // Reset state
    reset = 1'b1; contend = 1'b0; turbo = 1'b0;
    #1;
    repeat (3) begin tick(); chk("reset_state", outs, 6'b000001); end

    // Free run, 64 clocks
    reset = 1'b0; c = 0;
    n7p = 0; n7n = 0; n35p = 0; n35n = 0; n175 = 0; first_p = 0;
    for (int k = 1; k <= 64; k++) begin
      tick(); c = (c + 1) % 16;
      exp = STEADY[c];
      if (k <= 3) exp[0] = 1'b1;
      chk("free_run", outs, exp);
      n7p += ce7p; n7n += ce7n; n35p += ce35p; n35n += ce35n; n175 += ce175;
      if (ce35p && first_p == 0) first_p = k;
    end
    chk_int("cnt_ce7p", n7p, 16);
    chk_int("cnt_ce7n", n7n, 16);
    chk_int("cnt_ce35p", n35p, 8);
    chk_int("cnt_ce35n", n35n, 8);
    chk_int("cnt_ce175", n175, 4);
    chk_int("first_ce35p", first_p, 3);

    // Single stretch sampled at cnt=2; contend also high in non-sample slots
    tick(); chk("str_c1", outs, STEADY[1]);
    tick(); chk("str_c2", outs, STEADY[2]);
    contend = 1'b1;
    hi = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("stretch", outs, STR[i]);
      hi += cpuclk;
      if (i == 6) contend = 1'b0;
    end
    chk_int("stretch_cpuclk_hi", hi, 12);

    // Reset in the middle of a stretch
    tick(); chk("rst_c1", outs, STEADY[1]);
    tick(); chk("rst_c2", outs, STEADY[2]);
    contend = 1'b1;
    tick(); chk("rst_c3", outs, STR[0]);
    contend = 1'b0;
    tick(); chk("rst_c4", outs, STR[1]);
    tick(); chk("rst_c5", outs, STR[2]);
    reset = 1'b1;
    #1 chk("rst_async", outs, 6'b000001);
    repeat (2) begin tick(); chk("rst_hold", outs, 6'b000001); end
    reset = 1'b0; c = 0;
    for (int k = 1; k <= 8; k++) begin
      tick(); c = (c + 1) % 16;
      exp = STEADY[c];
      if (k <= 3) exp[0] = 1'b1;
      chk("rst_restart", outs, exp);
    end

    // Contend held high from reset
    reset = 1'b1; contend = 1'b1;
    tick();
    reset = 1'b0; c = 0;
    for (int k = 1; k <= 32; k++) begin
      tick(); c = (c + 1) % 16;
      exp = (STEADY[c] & 6'b110010) | 6'b000001;
      chk("contend_held", outs, exp);
    end
    contend = 1'b0;

`ifdef TURBO_EN
    // Turbo requested at cnt=4
    reset = 1'b1; turbo = 1'b0;
    tick();
    reset = 1'b0; c = 0;
    for (int k = 1; k <= 4; k++) begin
      tick(); c = (c + 1) % 16;
      exp = STEADY[c];
      if (k <= 3) exp[0] = 1'b1;
      chk("trb_pre", outs, exp);
    end
    turbo = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("trb_switch", outs, TRB[i]);
    end
    tick(); chk("trb_c4", outs, 6'b000000);
    contend = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      contend = 1'b0;
      chk("trb_stretch", outs, TRB2[i]);
    end
    turbo = 1'b0;
`endif

    chk_int("coincide", coinc, 0);
    chk_int("alternate", alt_err, 0);
    chk_int("min_gap_ge4", int'(min_gap >= 4), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
